chan_fifo: RTL and testbench



---
 rtl/chan_fifo.sv | 164 ++++++++++++++++
 tb/tb_chan_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_fifo.sv
// chan_fifo: single-clock channel FIFO for buffered Argo channels.
// Words are written into an inferred dual-port RAM with a registered read
// port and drained in order through a two-entry staging buffer (head + skid).
// Optional feature macro: CHAN_FIFO_COUNT_EN exposes the occupancy as port 'count'.
module chan_fifo #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef CHAN_FIFO_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]   count
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    // Storage and pointers
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    // Bookkeeping: total occupancy and words still sitting unread in RAM
    logic [ADDR_WIDTH:0]   occupancy;
    logic [ADDR_WIDTH:0]   occupancy_next;
    logic [ADDR_WIDTH:0]   unread;
    logic [ADDR_WIDTH:0]   unread_next;

    // A RAM read issued last cycle whose data is now on ram_q
    logic                  pending;

    // Output staging: head drives the receiver, skid catches an extra word
    logic                  head_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  head_valid_next;
    logic [DATA_WIDTH-1:0] head_data_next;
    logic                  skid_valid_next;
    logic [DATA_WIDTH-1:0] skid_data_next;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            in_flight;

    assign push      = in_valid && in_ready;
    assign pop       = head_valid && out_ready;
    assign out_valid = head_valid;
    assign out_data  = head_data;

`ifdef CHAN_FIFO_COUNT_EN
    assign count = occupancy;
`endif

    // Decide whether a RAM read may be issued: staged words plus the read in
    // flight, minus the word leaving now, must leave room for one more.
    always_comb begin
        in_flight = {2'b00, head_valid} + {2'b00, skid_valid}
                  + {2'b00, pending} - {2'b00, pop};
        issue     = (unread != '0) && (in_flight < 3'd2);
    end

    // Occupancy and unread counters move by at most one in each direction per edge
    always_comb begin
        occupancy_next = occupancy;
        unread_next    = unread;
        if (push && !pop) begin
            occupancy_next = occupancy + 1'b1;
        end else if (pop && !push) begin
            occupancy_next = occupancy - 1'b1;
        end
        if (push && !issue) begin
            unread_next = unread + 1'b1;
        end else if (issue && !push) begin
            unread_next = unread - 1'b1;
        end
    end

    // Staging update: on pop the skid advances, and returning RAM data fills
    // the first free slot (head if empty or leaving, otherwise skid).
    always_comb begin
        head_valid_next = head_valid;
        head_data_next  = head_data;
        skid_valid_next = skid_valid;
        skid_data_next  = skid_data;
        if (pop) begin
            if (skid_valid) begin
                head_valid_next = 1'b1;
                head_data_next  = skid_data;
                if (pending) begin
                    skid_valid_next = 1'b1;
                    skid_data_next  = ram_q;
                end else begin
                    skid_valid_next = 1'b0;
                end
            end else if (pending) begin
                head_valid_next = 1'b1;
                head_data_next  = ram_q;
            end else begin
                head_valid_next = 1'b0;
            end
        end else if (pending) begin
            if (!head_valid) begin
                head_valid_next = 1'b1;
                head_data_next  = ram_q;
            end else begin
                skid_valid_next = 1'b1;
                skid_data_next  = ram_q;
            end
        end
    end

    // RAM array with registered read; contents are never reset or exposed directly
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
        if (issue) begin
            ram_q <= mem[rd_ptr];
        end
    end

    // Control state: pointers, counters, read-pending flag and staging buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            unread     <= '0;
            in_ready   <= 1'b0;
            pending    <= 1'b0;
            head_valid <= 1'b0;
            head_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occupancy  <= occupancy_next;
            unread     <= unread_next;
            in_ready   <= (occupancy_next != DEPTH_CNT);
            pending    <= issue;
            head_valid <= head_valid_next;
            head_data  <= head_data_next;
            skid_valid <= skid_valid_next;
            skid_data  <= skid_data_next;
        end
    end

endmodule

// File: tb/tb_chan_fifo.sv
// tb_chan_fifo: scoreboard bench for chan_fifo (ADDR_WIDTH=3, DEPTH=8).
// Directed scenarios followed by randomized valid/ready traffic; a monitor
// compares every presented word against a queue of accepted words.
`timescale 1ns/1ps
module tb_chan_fifo;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef CHAN_FIFO_COUNT_EN
    logic [AW:0]   count;
`endif

    chan_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef CHAN_FIFO_COUNT_EN
        ,
        .count     (count)
`endif
    );

    int            check_count = 0;
    int            pass_count  = 0;
    logic [DW-1:0] exp_q[$];
    logic          seen_edge;
    logic          prev_hold;
    logic [DW-1:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [DW-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        apply_stimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        step();
        check_output("drain_empty", 64'(exp_q.size()), 64'd0);
        check_output("drain_valid", 64'(out_valid), 64'd0);
    endtask

    // Tracks whether an edge has occurred since reset released (in_ready lags by one edge)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen_edge <= 1'b0;
        else        seen_edge <= 1'b1;
    end

    // Monitor: between edges, compare outputs against the reference queue and
    // record the handshakes that the coming edge will perform
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_output("hold_valid", 64'(out_valid), 64'd1);
                check_output("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (seen_edge) begin
                check_output("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
            end
`ifdef CHAN_FIFO_COUNT_EN
            check_output("count", 64'(count), 64'(exp_q.size()));
`endif
            if (out_valid) begin
                check_output("valid_has_word", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check_output("out_data", 64'(out_data), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    // Hard time limit so the bench always ends
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int            pushed;
        int            cyc;
        logic          stalled;
        logic [DW-1:0] word;

        rst_n = 1'b0;
        apply_stimulus(1'b0, '0, 1'b0);

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_output("rst_in_ready", 64'(in_ready), 64'd0);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_out_data", 64'(out_data), 64'd0);
`ifdef CHAN_FIFO_COUNT_EN
        check_output("rst_count", 64'(count), 64'd0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check_output("rel_in_ready_low", 64'(in_ready), 64'd0);
        step();
        check_output("rel_in_ready_high", 64'(in_ready), 64'd1);

        // Single word latency: push at E1, visible after E3, popped at E4
        apply_stimulus(1'b1, 32'hA5A5_0001, 1'b1);
        step();
        apply_stimulus(1'b0, '0, 1'b1);
        check_output("lat_e1_valid", 64'(out_valid), 64'd0);
        step();
        check_output("lat_e2_valid", 64'(out_valid), 64'd0);
        step();
        check_output("lat_e3_valid", 64'(out_valid), 64'd1);
        check_output("lat_e3_data", 64'(out_data), 64'hA5A5_0001);
        step();
        check_output("lat_e4_valid", 64'(out_valid), 64'd0);
`ifdef CHAN_FIFO_COUNT_EN
        check_output("lat_e4_count", 64'(count), 64'd0);
`endif

        // Fill to full with the receiver stalled
        for (int i = 1; i <= DEPTH; i++) begin
            apply_stimulus(1'b1, DW'(i), 1'b0);
            step();
        end
        check_output("full_in_ready", 64'(in_ready), 64'd0);
        apply_stimulus(1'b1, 32'd9, 1'b0);
        repeat (3) step();
        check_output("full_hold_ready", 64'(in_ready), 64'd0);
        check_output("full_head_data", 64'(out_data), 64'd1);
`ifdef CHAN_FIFO_COUNT_EN
        check_output("full_count", 64'(count), 64'(DEPTH));
`endif

        // Drain from full while the 9th word is held on the input
        apply_stimulus(1'b1, 32'd9, 1'b1);
        #1 check_output("no_comb_ready", 64'(in_ready), 64'd0);
        for (int k = 0; k < DEPTH; k++) begin
            check_output("drain_stream_valid", 64'(out_valid), 64'd1);
            check_output("drain_stream_data", 64'(out_data), 64'(k + 1));
            step();
            if (k == 0) check_output("ready_after_pop", 64'(in_ready), 64'd1);
            if (k == 1) apply_stimulus(1'b0, '0, 1'b1);
        end
        check_output("ninth_word", 64'(out_data), 64'd9);
        drain(50);

        // Continuous streaming of 20 words, wrapping the pointers
        for (int j = 0; j < 24; j++) begin
            apply_stimulus(j < 20, DW'(100 + j), 1'b1);
            step();
            if (j >= 2 && j <= 21) begin
                check_output("stream_valid", 64'(out_valid), 64'd1);
                check_output("stream_data", 64'(out_data), 64'(100 + j - 2));
            end
            if (j == 22) check_output("stream_end_valid", 64'(out_valid), 64'd0);
        end
        drain(50);

        // Asynchronous reset with five words buffered
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, DW'(200 + i), 1'b0);
            step();
        end
        apply_stimulus(1'b0, '0, 1'b0);
        step();
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_output("async_rst_valid", 64'(out_valid), 64'd0);
        check_output("async_rst_ready", 64'(in_ready), 64'd0);
`ifdef CHAN_FIFO_COUNT_EN
        check_output("async_rst_count", 64'(count), 64'd0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        apply_stimulus(1'b1, 32'h77, 1'b1);
        step();
        apply_stimulus(1'b0, '0, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) step();
        check_output("post_rst_valid", 64'(out_valid), 64'd1);
        check_output("post_rst_first", 64'(out_data), 64'h77);
        drain(50);

        // Randomized traffic: alternate fill-biased and drain-biased phases
        pushed  = 0;
        cyc     = 0;
        stalled = 1'b0;
        word    = '0;
        while (pushed < 1000 && cyc < 20000) begin
            if (!stalled) begin
                word = $urandom;
                in_valid = ($urandom_range(0, 99) < 70);
                in_data  = word;
            end
            if (((pushed / 100) % 2) == 0) out_ready = ($urandom_range(0, 99) < 30);
            else                           out_ready = ($urandom_range(0, 99) < 85);
            if (in_valid && in_ready) pushed++;
            stalled = in_valid && !in_ready;
            step();
            cyc++;
        end
        check_output("random_pushed", 64'(pushed), 64'd1000);
        drain(200);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
